// File: rtl/fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : fifo_wr_arbiter
// Description : Round-robin, packet-holding arbiter for a shared FIFO write port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int c_id_w  = $clog2(NUM_REQ);
  localparam int c_cnt_w = $clog2(MAX_BURST) + 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MAX_BURST - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [c_id_w-1:0]   owner_q, owner_d;
  logic [c_id_w-1:0]   rr_ptr_q, rr_ptr_d;
  logic [c_cnt_w-1:0]  beat_cnt_q, beat_cnt_d;

  logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];
  logic [c_id_w-1:0]     pick_idx;
  logic                  beat;
  logic                  release_beat;

  // (base + off) mod NUM_REQ without requiring NUM_REQ to be a power of two
  function automatic logic [c_id_w-1:0] rr_index(input logic [c_id_w-1:0] base,
                                                 input int unsigned        off);
    logic [c_id_w:0] sum;
    sum = {1'b0, base} + (c_id_w+1)'(off);
    if (sum >= (c_id_w+1)'(NUM_REQ)) begin
      sum = sum - (c_id_w+1)'(NUM_REQ);
    end
    return sum[c_id_w-1:0];
  endfunction

  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
      assign data_slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_idx = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[rr_index(rr_ptr_q, i)]) begin
        pick_idx = rr_index(rr_ptr_q, i);
      end
    end
  end

  assign beat         = (state_q == ST_GRANT) & req_valid[owner_q] & ~fifo_full;
  assign release_beat = beat & (req_last[owner_q] | (beat_cnt_q == c_cnt_last));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          owner_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
        if (release_beat) begin
          state_d  = ST_IDLE;
          rr_ptr_d = rr_index(owner_q, 1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    req_ready          = '0;
    req_ready[owner_q] = beat;
  end

  assign fifo_wr_en   = beat;
  assign fifo_data_in = (state_q == ST_GRANT) ? data_slice[owner_q] : '0;
  assign grant_id     = owner_q;
  assign busy         = (state_q == ST_GRANT);

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_wr_en_ready:  assert property (@(posedge clk) disable iff (rst) fifo_wr_en == |req_ready);
  a_no_full_wr:   assert property (@(posedge clk) disable iff (rst) !(fifo_wr_en && fifo_full));

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_fifo_wr_arbiter
// Description : Self-checking bench for fifo_wr_arbiter (scoreboard + vector table).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DW        = 32;
  localparam int MAX_BURST = 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_last;
  logic [NUM_REQ*DW-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  fifo_full;
  logic                  fifo_wr_en;
  logic [DW-1:0]         fifo_data_in;
  logic [1:0]            grant_id;
  logic                  busy;

  fifo_wr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_data_in(fifo_data_in),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] rq_data [NUM_REQ][$];
  bit            rq_last [NUM_REQ][$];
  bit            en [NUM_REQ];
  bit            full_v;
  logic [DW-1:0] exp_q [$];
  int            wr_cyc [$];
  int            wr_gid [$];
  int            cyc;
  int            grants;
  bit            prev_busy;

  typedef struct {
    int req;
    int len;
    int exp_steps;
    int exp_grants;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int r, input int k);
    return DW'((r << 24) | k);
  endfunction

  task automatic send(input int r, input int base, input int n);
    for (int k = 0; k < n; k++) begin
      rq_data[r].push_back(mk(r, base + k));
      rq_last[r].push_back(k == n - 1);
    end
  endtask

  task automatic exp_push(input int r, input int base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(mk(r, base + k));
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NUM_REQ; i++) if (rq_data[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NUM_REQ; i++) begin
      rq_data[i].delete();
      rq_last[i].delete();
      en[i] = 1'b1;
    end
    exp_q.delete();
    wr_cyc.delete();
    wr_gid.delete();
    grants    = 0;
    prev_busy = 1'b0;
    full_v    = 1'b0;
  endtask

  // One clock: drive at negedge, sample the combinational response 1 time unit later.
  task automatic step();
    @(negedge clk);
    fifo_full = full_v;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (en[i] && rq_data[i].size() != 0) begin
        req_valid[i]           = 1'b1;
        req_last[i]            = rq_last[i][0];
        req_data[i*DW +: DW]   = rq_data[i][0];
      end else begin
        req_valid[i]           = 1'b0;
        req_last[i]            = 1'b0;
        req_data[i*DW +: DW]   = '0;
      end
    end
    #1;
    cyc++;
    if (!rst) begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      check("wr_en_vs_ready", fifo_wr_en, |req_ready);
      if (fifo_full) check("wr_en_while_full", fifo_wr_en, 1'b0);
    end
    if (fifo_wr_en === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_gid.push_back(int'(grant_id));
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: actual=%0h required=no write (cycle %0d)", fifo_data_in, cyc);
      end else begin
        check("fifo_data", fifo_data_in, exp_q.pop_front());
      end
      check("ready_is_owner", req_ready[grant_id], 1'b1);
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] === 1'b1 && rq_data[i].size() != 0) begin
        void'(rq_data[i].pop_front());
        void'(rq_last[i].pop_front());
      end
    end
    if (busy === 1'b1 && !prev_busy) grants++;
    prev_busy = (busy === 1'b1);
  endtask

  task automatic do_reset(input int n);
    clear_all();
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    clear_all();
  endtask

  task automatic run_idle(input string name, input int bound, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(all_empty() && busy === 1'b0) && n < bound);
    if (n >= bound) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: actual=%0d cycles required=<%0d", name, n, bound);
    end
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{req: 0, len: 1,  exp_steps: 3,  exp_grants: 1};
    vecs[1] = '{req: 2, len: 3,  exp_steps: 5,  exp_grants: 1};
    vecs[2] = '{req: 3, len: 8,  exp_steps: 10, exp_grants: 1};
    vecs[3] = '{req: 1, len: 9,  exp_steps: 12, exp_grants: 2};
    vecs[4] = '{req: 2, len: 16, exp_steps: 19, exp_grants: 2};
    vecs[5] = '{req: 1, len: 10, exp_steps: 13, exp_grants: 2};

    cyc       = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    clear_all();

    // Reset held with every requester valid
    for (int r = 0; r < NUM_REQ; r++) send(r, 0, 2);
    step();
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_busy", busy, 1'b0);
      check("rst_wr_en", fifo_wr_en, 1'b0);
      check("rst_ready", req_ready, 4'b0);
      check("rst_data", fifo_data_in, 32'd0);
    end

    // Single 3-beat packet from requester 2
    do_reset(2);
    send(2, 0, 3);
    exp_push(2, 0, 3);
    step();
    check("single_idle_busy", busy, 1'b0);
    check("single_idle_wr", fifo_wr_en, 1'b0);
    step();
    check("single_busy", busy, 1'b1);
    check("single_gid", grant_id, 2'd2);
    check("single_wr_a", fifo_wr_en, 1'b1);
    step();
    check("single_wr_b", fifo_wr_en, 1'b1);
    step();
    check("single_wr_c", fifo_wr_en, 1'b1);
    step();
    check("single_busy_drop", busy, 1'b0);
    check("single_drain", exp_q.size(), 0);

    // Round robin over continuous single-beat packets
    do_reset(2);
    for (int p = 0; p < 2; p++) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        send(r, p, 1);
        exp_push(r, p, 1);
      end
    end
    run_idle("rr", 100, n);
    check("rr_writes", wr_gid.size(), 8);
    for (int i = 0; i < wr_gid.size(); i++) begin
      check("rr_order", wr_gid[i], i % NUM_REQ);
      if (i > 0) check("rr_gap", wr_cyc[i] - wr_cyc[i-1], 2);
    end

    // Backpressure on cycles 2-5 of a 4-beat packet
    do_reset(2);
    send(0, 0, 4);
    exp_push(0, 0, 4);
    step();
    step();
    check("bp_beat1", fifo_wr_en, 1'b1);
    full_v = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("bp_wr_blocked", fifo_wr_en, 1'b0);
      check("bp_ready_blocked", req_ready, 4'b0);
      check("bp_busy_held", busy, 1'b1);
    end
    full_v = 1'b0;
    step();
    check("bp_beat2", fifo_wr_en, 1'b1);
    run_idle("bp", 50, n);
    check("bp_writes", wr_cyc.size(), 4);

    // Vector table: single requester, packet length versus burst limit
    for (int v = 0; v < 6; v++) begin
      do_reset(2);
      send(vecs[v].req, 0, vecs[v].len);
      exp_push(vecs[v].req, 0, vecs[v].len);
      run_idle("vec", 100, n);
      check("vec_steps", n, vecs[v].exp_steps);
      check("vec_grants", grants, vecs[v].exp_grants);
    end

    // MAX_BURST truncation with requester 3 pending
    do_reset(2);
    send(1, 0, 10);
    send(3, 0, 3);
    exp_push(1, 0, 8);
    exp_push(3, 0, 3);
    exp_push(1, 8, 2);
    run_idle("trunc", 100, n);
    check("trunc_grants", grants, 3);
    check("trunc_writes", wr_cyc.size(), 13);

    // Reset in the middle of a packet
    do_reset(2);
    send(2, 0, 1);
    exp_push(2, 0, 1);
    run_idle("mid_pre", 50, n);
    send(1, 0, 5);
    exp_push(1, 0, 2);
    step();
    step();
    step();
    en[1] = 1'b0;
    rst   = 1'b1;
    step();
    rst = 1'b0;
    rq_data[1].delete();
    rq_last[1].delete();
    en[1] = 1'b1;
    step();
    check("mid_busy_after_rst", busy, 1'b0);
    check("mid_wr_after_rst", fifo_wr_en, 1'b0);
    check("mid_partial_drain", exp_q.size(), 0);
    wr_gid.delete();
    send(0, 0, 2);
    send(3, 0, 1);
    exp_push(0, 0, 2);
    exp_push(3, 0, 1);
    run_idle("mid_post", 50, n);
    check("mid_first_gid", (wr_gid.size() > 0) ? wr_gid[0] : -1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
